song_player: RTL and testbench
==============================

// Module: song_player
// PURPOSE
//  Autoplay source for the piano note/octave interface: reads a melody from an external sync ROM
//  and drives the same one-hot note lines (a..g) and octave up/down pulse lines as the key panel.
//  Sits upstream of the tone/segment block, muxed against the physical keys; on one clock domain.
//  Tracks the downstream octave internally and emits up/down pulses to reach each note's octave.
// PARAMETERS
//  TICK_DIV   1000  clock cycles per duration tick (>=1)
//  SONG_LEN   16    number of ROM entries played (1..256)
//  PULSE_CYC  4     cycles an up/down pulse is held high, and the low gap after it (>=1)
//  GAP_CYC    2     cycles all keys low between consecutive entries (0 = no gap)
//  OCT_INIT   1     downstream octave after reset (0..3)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous reset, active-high
//  start     in   1  begin playback from entry 0 (ignored while busy)
//  stop      in   1  abort playback; wins over start
//  rom_addr  out  8  ROM entry index
//  rom_data  in   8  entry: [2:0] note 0=rest,1..7=a..g; [4:3] octave 0..3; [7:5] dur, ticks=dur+1
//  a..g      out  1  one-hot note lines (each a separate 1-bit port); all 0 = silence
//  up        out  1  octave-up pulse
//  down      out  1  octave-down pulse
//  busy      out  1  high from start acceptance until done/stop
//  done      out  1  1-cycle pulse at end of song
// BEHAVIOUR
//  - All outputs registered. Reset: a..g=0, up=down=0, busy=0, done=0, rom_addr=0, idx=0,
//    octave model=OCT_INIT, state=IDLE. Reset overrides everything, in any state.
//  - ROM read latency 1 cycle: rom_data is valid in the cycle after rom_addr is presented.
//  - FSM: IDLE -> FETCH -> LOAD -> {SHIFT_HI <-> SHIFT_LO}* -> NOTE -> GAP -> FETCH | IDLE.
//  - IDLE: start=1 & stop=0 -> FETCH, busy<=1, idx<=0.
//  - FETCH: rom_addr<=idx. LOAD: latch rom_data. If octave field == model -> NOTE, else SHIFT_HI.
//  - SHIFT_HI: up (target>model) or down (target<model) held high PULSE_CYC cycles. Model +/-1 on
//    entry. SHIFT_LO: up=down=0 for PULSE_CYC cycles. Then recompare: -> SHIFT_HI or NOTE.
//    Keys are 0 throughout shifting. up and down are never high together.
//  - NOTE: the selected line is high (one-hot) for (dur+1)*TICK_DIV cycles. A rest keeps all keys 0
//    for the same time and does no octave shift; its octave field is ignored.
//  - GAP: keys 0 for GAP_CYC cycles (skipped if 0). Then idx+1: if idx < SONG_LEN-1 -> FETCH,
//    else end of song.
//  - Latency: start sampled at edge N; first note line (no shift) rises at edge N+3.
//  - End of song: done=1 for one cycle, busy<=0, -> IDLE. The octave model is kept, not reset.
//  - stop=1 in any non-IDLE state: at the next edge -> IDLE, keys/up/down<=0, busy<=0, no done.
//    A truncated pulse still counts in the model (it was updated on entry).
//  - start and stop in the same cycle: stop wins; stays or goes IDLE.
//  - Durations: 3-bit dur, counters sized for 8*TICK_DIV; no wrap inside a note.
// CONFIGURATION
//  LOOP_EN defined: at end of song idx wraps to 0 and goes to FETCH. done is never pulsed and busy
//    stays 1 until stop. Octave continuity is preserved across the wrap.
//  LOOP_EN undefined: single pass, ends with the done pulse as above.
// TESTING (TICK_DIV=4, PULSE_CYC=2, GAP_CYC=1, SONG_LEN=4, OCT_INIT=1)
//  1. ROM = {c o1 d0, e o1 d1, rest d0, g o1 d0}; pulse start
//     -> c high 4 cyc, gap 1; e high 8; 0 for 4; g high 4; done 1 cyc; busy falls with done.
//  2. Entry a o3 d0 first -> up 2 hi/2 lo twice, then a high 4 cyc; next b o0 ->
//     3 down pulses, then b high.
//  3. stop asserted mid-NOTE of entry 1 -> next edge all keys 0, busy 0, done stays 0;
//     a restart plays from entry 0.
//  4. start+stop in the same cycle from IDLE -> stays IDLE, busy 0;
//     start while busy -> no effect on timing.
//  5. rst high mid SHIFT_HI -> next edge up=0, model=OCT_INIT, rom_addr 0, IDLE.
//  6. LOOP_EN defined, case-1 ROM -> after g, rom_addr returns to 0 and c replays;
//     done never pulses; stop ends it.

Source files
------------

// File: rtl/song_player_if.sv
// rtl/song_player_if.sv - start/stop control, melody ROM port and key/octave outputs of song_player
interface song_player_if;
    logic       start;
    logic       stop;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       a, b, c, d, e, f, g;
    logic       up;
    logic       down;
    logic       busy;
    logic       done;

    modport master (
        input  start, stop, rom_data,
        output rom_addr, a, b, c, d, e, f, g, up, down, busy, done
    );

    modport slave (
        output start, stop, rom_data,
        input  rom_addr, a, b, c, d, e, f, g, up, down, busy, done
    );
endinterface

// File: rtl/song_player.sv
// rtl/song_player.sv - melody autoplayer driving one-hot note lines and octave up/down pulses
// Optional feature: define LOOP_EN to replay the song endlessly until stop.
module song_player #(
    parameter int TICK_DIV  = 1000,
    parameter int SONG_LEN  = 16,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int OCT_INIT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    song_player_if.master bus
);
    localparam int CMAX_A = (8 * TICK_DIV > PULSE_CYC) ? 8 * TICK_DIV : PULSE_CYC;
    localparam int CMAX   = (CMAX_A > GAP_CYC) ? CMAX_A : GAP_CYC;
    localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [7:0]    LAST_IDX   = 8'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SHIFT_HI, S_SHIFT_LO, S_NOTE, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    rom_addr_q, rom_addr_d;
    logic [2:0]    note_q, note_d;
    logic [1:0]    oct_q, oct_d;
    logic [2:0]    dur_q, dur_d;
    logic [1:0]    model_q, model_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ld_wait_q, ld_wait_d;
    logic [6:0]    keys_q, keys_d;
    logic          up_q, up_d;
    logic          down_q, down_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // In LOAD the fresh ROM byte is used directly; after a shift the latched copy is used.
    logic          from_rom;
    logic [2:0]    sel_note, sel_dur;
    logic [1:0]    sel_oct;
    logic [6:0]    sel_keys;
    logic [CW-1:0] note_len;
    logic          decide, advance, shift_up;

    assign from_rom = (state_q == S_LOAD);
    assign sel_note = from_rom ? bus.rom_data[2:0] : note_q;
    assign sel_oct  = from_rom ? bus.rom_data[4:3] : oct_q;
    assign sel_dur  = from_rom ? bus.rom_data[7:5] : dur_q;
    assign sel_keys = (sel_note == 3'd0) ? 7'd0 : 7'(7'd1 << (sel_note - 3'd1));
    assign note_len = CW'((int'(sel_dur) + 1) * TICK_DIV - 1);
    assign shift_up = (sel_oct > model_q);
    assign decide   = (state_q == S_LOAD && !ld_wait_q) ||
                      (state_q == S_SHIFT_LO && cnt_q == '0);
    assign advance  = (state_q == S_GAP && cnt_q == '0) ||
                      (state_q == S_NOTE && cnt_q == '0 && GAP_CYC == 0);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        oct_d      = oct_q;
        dur_d      = dur_q;
        model_d    = model_q;
        cnt_d      = cnt_q;
        ld_wait_d  = ld_wait_q;
        keys_d     = keys_q;
        up_d       = up_q;
        down_d     = down_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    idx_d   = 8'd0;
                end
            end
            S_FETCH: begin
                rom_addr_d = idx_q;
                ld_wait_d  = 1'b1;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                ld_wait_d = 1'b0;
                if (!ld_wait_q) begin
                    note_d = bus.rom_data[2:0];
                    oct_d  = bus.rom_data[4:3];
                    dur_d  = bus.rom_data[7:5];
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT_LO;
                    up_d    = 1'b0;
                    down_d  = 1'b0;
                    cnt_d   = PULSE_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT_LO, S_NOTE, S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (state_q == S_NOTE) begin
                    keys_d = 7'd0;
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LAST;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Rests skip octave tracking entirely; the model moves as each pulse begins.
        if (decide) begin
            if (sel_note == 3'd0 || sel_oct == model_q) begin
                state_d = S_NOTE;
                keys_d  = sel_keys;
                cnt_d   = note_len;
            end else begin
                state_d = S_SHIFT_HI;
                up_d    = shift_up;
                down_d  = !shift_up;
                model_d = shift_up ? model_q + 2'd1 : model_q - 2'd1;
                cnt_d   = PULSE_LAST;
            end
        end

        if (advance) begin
            if (idx_q != LAST_IDX) begin
                idx_d   = idx_q + 8'd1;
                state_d = S_FETCH;
            end else begin
`ifdef LOOP_EN
                idx_d   = 8'd0;
                state_d = S_FETCH;
`else
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`endif
            end
        end

        if (bus.stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            keys_d  = 7'd0;
            up_d    = 1'b0;
            down_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'd0;
            rom_addr_q <= 8'd0;
            note_q     <= 3'd0;
            oct_q      <= 2'd0;
            dur_q      <= 3'd0;
            model_q    <= 2'(OCT_INIT);
            cnt_q      <= '0;
            ld_wait_q  <= 1'b0;
            keys_q     <= 7'd0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            oct_q      <= oct_d;
            dur_q      <= dur_d;
            model_q    <= model_d;
            cnt_q      <= cnt_d;
            ld_wait_q  <= ld_wait_d;
            keys_q     <= keys_d;
            up_q       <= up_d;
            down_q     <= down_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.a        = keys_q[0];
    assign bus.b        = keys_q[1];
    assign bus.c        = keys_q[2];
    assign bus.d        = keys_q[3];
    assign bus.e        = keys_q[4];
    assign bus.f        = keys_q[5];
    assign bus.g        = keys_q[6];
    assign bus.up       = up_q;
    assign bus.down     = down_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - scoreboard bench for song_player (build with LOOP_EN for the replay case)
module tb_song_player;
    localparam int TICK  = 4;
    localparam int PULSE = 2;
    localparam int GAP   = 1;
    localparam int LEN   = 4;
    localparam int OCTI  = 1;

    typedef struct {
        int val;
        int len;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    song_player_if bus();

    song_player #(
        .TICK_DIV (TICK),
        .SONG_LEN (LEN),
        .PULSE_CYC(PULSE),
        .GAP_CYC  (GAP),
        .OCT_INIT (OCTI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:255];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    wire [6:0] keys = {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
    wire [8:0] vec  = {bus.up, bus.down, keys};

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_seen = 0;
    int   exp_oct  = OCTI;
    bit   sb_en    = 1'b1;
    ev_t  exp_q[$];
    int   cur_vec  = 0;
    int   run_len  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Each contiguous non-zero output pattern is one event: (pattern, length in cycles).
    always @(negedge clk) begin
        if (int'(vec) == cur_vec && cur_vec != 0) begin
            run_len++;
        end else begin
            if (cur_vec != 0 && sb_en) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", cur_vec, 0);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("sb_val", cur_vec, ev.val);
                    check("sb_len", run_len, ev.len);
                end
            end
            cur_vec = int'(vec);
            run_len = 1;
        end
        if (bus.done) begin
            done_seen++;
            check("busy_low_with_done", int'(bus.busy), 0);
        end
    end

    task automatic push_ev(input int val, input int len);
        ev_t ev;
        ev.val = val;
        ev.len = len;
        exp_q.push_back(ev);
    endtask

    // Reference timing: FETCH 1 + LOAD 2 cycles, 2*PULSE per shift, note, then gap.
    task automatic plan_song(output int total, output int first);
        int oct;
        oct   = exp_oct;
        total = 0;
        first = -1;
        for (int i = 0; i < LEN; i++) begin
            logic [7:0] ent;
            int n, o, len;
            ent = rom[i];
            n   = int'(ent[2:0]);
            o   = int'(ent[4:3]);
            len = (int'(ent[7:5]) + 1) * TICK;
            total += 3;
            if (n != 0) begin
                while (oct != o) begin
                    if (o > oct) begin
                        push_ev(9'h100, PULSE);
                        oct++;
                    end else begin
                        push_ev(9'h080, PULSE);
                        oct--;
                    end
                    total += 2 * PULSE;
                end
                if (first < 0) first = total;
                push_ev(1 << (n - 1), len);
            end
            total += len + GAP;
        end
        exp_oct = oct;
    endtask

    task automatic run_song(input string tag, input int restart_at);
        int total, first, k, first_key;
        bit got_done;
        plan_song(total, first);
        k = 0;
        first_key = -1;
        got_done = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        while (!got_done && k < 1000) begin
            @(negedge clk);
            k++;
            bus.start = (k == restart_at);
            if (first_key < 0 && keys != 7'd0) first_key = k;
            if (bus.done) got_done = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, "_first_key"}, first_key, first);
        check({tag, "_done_cycle"}, k, total);
        @(negedge clk);
        check({tag, "_done_1cyc"}, int'(bus.done), 0);
        check({tag, "_busy_after"}, int'(bus.busy), 0);
        check({tag, "_sb_drain"}, exp_q.size(), 0);
    endtask

    task automatic load_rom(input logic [7:0] e0, e1, e2, e3);
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
    endtask

    task automatic wait_key(input string tag, input int want_vec);
        int k;
        k = 0;
        while (int'(vec) != want_vec && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_wait"}, int'(int'(vec) == want_vec), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1);
    end

    initial begin
        int d0, total, first;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_keys", int'(vec), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_addr", int'(bus.rom_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // c o1 d0, e o1 d1, rest d0, g o1 d0
        load_rom(8'h0B, 8'h2D, 8'h00, 8'h0F);
`ifdef LOOP_EN
        plan_song(total, first);
        exp_oct = OCTI;
        plan_song(total, first);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int k = 1; k <= 2 * total; k++) begin
            @(negedge clk);
            if (k == total) check("loop_addr_last", int'(bus.rom_addr), LEN - 1);
            if (k == total + 1) check("loop_addr_wrap", int'(bus.rom_addr), 0);
        end
        check("loop_busy", int'(bus.busy), 1);
        bus.stop = 1'b1;
        @(negedge clk) bus.stop = 1'b0;
        check("loop_stop_busy", int'(bus.busy), 0);
        check("loop_no_done", done_seen, 0);
        check("loop_sb_drain", exp_q.size(), 0);
`else
        run_song("t1", -1);
        check("t1_done_count", done_seen, 1);

        // start and stop together from IDLE
        @(negedge clk) begin bus.start = 1'b1; bus.stop = 1'b1; end
        @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
        check("t4_busy", int'(bus.busy), 0);
        repeat (5) @(negedge clk);
        check("t4_keys", int'(vec), 0);

        // extra start while busy must not disturb timing
        run_song("t4b", 10);

        // a o3 d0, b o0 d0, rest, rest
        load_rom(8'h19, 8'h02, 8'h00, 8'h00);
        run_song("t2", -1);

        // stop in the middle of entry 1's note
        load_rom(8'h0B, 8'h2D, 8'h00, 8'h0F);
        sb_en = 1'b0;
        d0 = done_seen;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        wait_key("t3", 9'h010);
        repeat (2) @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk) bus.stop = 1'b0;
        check("t3_keys", int'(vec), 0);
        check("t3_busy", int'(bus.busy), 0);
        check("t3_done", int'(bus.done), 0);
        repeat (20) @(negedge clk);
        check("t3_no_done", done_seen, d0);
        exp_oct = 1;  // entry 0 (octave 1) shifted the model before the stop
        exp_q.delete();
        sb_en = 1'b1;
        run_song("t3r", -1);

        // reset while the first up pulse is high
        load_rom(8'h19, 8'h02, 8'h00, 8'h00);
        sb_en = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        wait_key("t5", 9'h100);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("t5_up", int'(bus.up), 0);
        check("t5_busy", int'(bus.busy), 0);
        check("t5_addr", int'(bus.rom_addr), 0);
        repeat (3) @(negedge clk);
        exp_oct = OCTI;
        exp_q.delete();
        sb_en = 1'b1;
        run_song("t5r", -1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
